// File: rtl/mapper_ram_bridge.sv
// mapper_ram_bridge
//   Bridges single-byte CPU cycles that target mapper RAM onto a simple
//   req/ack memory port. A one-entry read buffer (tag + byte) answers a
//   repeat read of the same address without touching memory. Accesses that
//   are never acknowledged are abandoned after TIMEOUT cycles.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   req_i, ram_cs_i       one-cycle start strobe, mapper RAM select
//   rnw_i, addr_i, wdata_i  direction (1 = read), byte address, write data
//   rdata_o, rdata_valid_o  read data (held) and one-cycle completion pulse
//   wait_o                CPU wait request
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o   memory request side
//   mem_ack_i, mem_rdata_i                         memory completion side
//   err_timeout_o, err_overrun_o, err_clr_i        sticky error flags / clear
module mapper_ram_bridge #(
    parameter int AW      = 27,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_i,
    input  logic          ram_cs_i,
    input  logic          rnw_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o,
    output logic          rdata_valid_o,
    output logic          wait_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [7:0]    mem_rdata_i,
    output logic          err_timeout_o,
    output logic          err_overrun_o,
    input  logic          err_clr_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Counter value seen in the last ISSUE cycle before giving up; an ack in
    // that same cycle still completes normally.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);

    state_t        state, state_nx;
    logic          rnw_q;
    logic [7:0]    cnt;
    logic          buf_valid;
    logic [AW-1:0] buf_tag;
    logic [7:0]    buf_data;

    logic          accept;
    logic          overrun;
    logic          hit;
    logic          done_ack;
    logic          done_to;
    logic          tag_match_wr;

    always_comb begin
        accept       = req_i && ram_cs_i && (state == IDLE);
        overrun      = req_i && ram_cs_i && (state != IDLE);
        hit          = rnw_i && buf_valid && (buf_tag == addr_i);
        done_ack     = (state == ISSUE) && mem_ack_i;
        done_to      = (state == ISSUE) && !mem_ack_i && (cnt == CNT_LAST);
        tag_match_wr = buf_valid && (buf_tag == mem_addr_o);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = hit ? RESP : ISSUE;
            ISSUE:   if (done_ack || done_to) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o     = (state == ISSUE);
        mem_we_o      = (state == ISSUE) && !rnw_q;
        rdata_valid_o = (state == RESP) && rnw_q;
        // Gated by reset_n so a strobe seen while reset is held cannot
        // raise a wait request.
        wait_o        = reset_n &&
                        (((state == IDLE) && req_i && ram_cs_i) || (state != IDLE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latch, read data and timeout counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rnw_q       <= 1'b1;
            rdata_o     <= 8'hFF;
            cnt         <= '0;
        end else begin
            if (accept) begin
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
                rnw_q       <= rnw_i;
                cnt         <= '0;
                if (hit) begin
                    rdata_o <= buf_data;
                end
            end else if ((state == ISSUE) && !mem_ack_i && (cnt != CNT_MAX)) begin
                cnt <= cnt + 8'd1;
            end

            if (done_ack && rnw_q) begin
                rdata_o <= mem_rdata_i;
            end else if (done_to && rnw_q) begin
                rdata_o <= 8'hFF;
            end
        end
    end

    // One-entry read buffer; timed-out accesses never touch it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (done_ack) begin
            if (rnw_q) begin
                buf_valid <= 1'b1;
                buf_tag   <= mem_addr_o;
                buf_data  <= mem_rdata_i;
            end else if (tag_match_wr) begin
                buf_data  <= mem_wdata_o;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as err_clr_i wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_o <= 1'b0;
            err_overrun_o <= 1'b0;
        end else begin
            err_timeout_o <= done_to || (err_timeout_o && !err_clr_i);
            err_overrun_o <= overrun || (err_overrun_o && !err_clr_i);
        end
    end

endmodule

// File: tb/tb_mapper_ram_bridge.sv
module tb_mapper_ram_bridge;

    localparam int AW = 27;
    localparam int TO = 8;

    logic          clk;
    logic          reset_n;
    logic          req_i;
    logic          ram_cs_i;
    logic          rnw_i;
    logic [AW-1:0] addr_i;
    logic [7:0]    wdata_i;
    logic [7:0]    rdata_o;
    logic          rdata_valid_o;
    logic          wait_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wdata_o;
    logic          mem_ack_i;
    logic [7:0]    mem_rdata_i;
    logic          err_timeout_o;
    logic          err_overrun_o;
    logic          err_clr_i;

    mapper_ram_bridge #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_i         (req_i),
        .ram_cs_i      (ram_cs_i),
        .rnw_i         (rnw_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .wait_o        (wait_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .err_timeout_o (err_timeout_o),
        .err_overrun_o (err_overrun_o),
        .err_clr_i     (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one buffered byte, the held read data and the flags.
    bit            m_valid;
    logic [AW-1:0] m_tag;
    logic [7:0]    m_data;
    logic [7:0]    m_rdata;
    bit            m_err_to;
    bit            m_err_ov;

    logic [AW-1:0] pool [6];

    task automatic model_reset();
        m_valid  = 0;
        m_tag    = '0;
        m_data   = '0;
        m_rdata  = 8'hFF;
        m_err_to = 0;
        m_err_ov = 0;
    endtask

    // One CPU access. ack_dly = ISSUE cycles before ack (>= TO means never).
    // ovr_at = ISSUE cycle index in which a second strobe arrives (-1: none).
    task automatic do_access(input bit rnw, input logic [AW-1:0] addr,
                             input logic [7:0] wd, input int ack_dly,
                             input logic [7:0] md, input int ovr_at,
                             input bit clr_ovr, input string nm);
        bit hit;
        bit timed_out;
        bit did_ovr;
        hit       = rnw && m_valid && (m_tag == addr);
        timed_out = (ack_dly >= TO);
        did_ovr   = 0;

        @(negedge clk);
        req_i = 1; ram_cs_i = 1; rnw_i = rnw; addr_i = addr; wdata_i = wd;
        mem_ack_i = 0;
        #1;
        total++; if (wait_o !== 1'b1) begin bad++; $display("FAIL %s wait_on_req got=%b exp=1", nm, wait_o); end

        @(negedge clk);
        req_i = 0; addr_i = AW'($urandom); wdata_i = 8'($urandom); rnw_i = 1'($urandom);
        if (!hit) begin
            for (int i = 0; i < TO; i++) begin
                mem_ack_i   = (i == ack_dly);
                mem_rdata_i = (i == ack_dly) ? md : 8'($urandom);
                if (i == ovr_at) begin
                    req_i = 1; ram_cs_i = 1; rnw_i = 1'($urandom);
                    addr_i = AW'($urandom); err_clr_i = clr_ovr;
                    did_ovr = 1;
                    if (clr_ovr) m_err_to = 0;
                end
                #1;
                total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL %s mem_req[%0d] got=%b exp=1", nm, i, mem_req_o); end
                total++; if (mem_we_o !== !rnw) begin bad++; $display("FAIL %s mem_we[%0d] got=%b exp=%b", nm, i, mem_we_o, !rnw); end
                total++; if (mem_addr_o !== addr) begin bad++; $display("FAIL %s mem_addr[%0d] got=%h exp=%h", nm, i, mem_addr_o, addr); end
                total++; if (mem_wdata_o !== wd) begin bad++; $display("FAIL %s mem_wdata[%0d] got=%h exp=%h", nm, i, mem_wdata_o, wd); end
                total++; if (wait_o !== 1'b1 || rdata_valid_o !== 1'b0) begin bad++; $display("FAIL %s issue_wait_valid[%0d] got=%b%b exp=10", nm, i, wait_o, rdata_valid_o); end
                @(negedge clk);
                req_i = 0; err_clr_i = 0; mem_ack_i = 0; mem_rdata_i = 8'($urandom);
                if (i == ack_dly) break;
            end
        end

        if (did_ovr) m_err_ov = 1;
        if (hit) begin
            m_rdata = m_data;
        end else if (timed_out) begin
            if (rnw) m_rdata = 8'hFF;
            m_err_to = 1;
        end else if (rnw) begin
            m_valid = 1; m_tag = addr; m_data = md; m_rdata = md;
        end else if (m_valid && m_tag == addr) begin
            m_data = wd;
        end

        // Response cycle.
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL %s resp_mem_req got=%b exp=0", nm, mem_req_o); end
        total++; if (wait_o !== 1'b1) begin bad++; $display("FAIL %s resp_wait got=%b exp=1", nm, wait_o); end
        total++; if (rdata_valid_o !== rnw) begin bad++; $display("FAIL %s resp_valid got=%b exp=%b", nm, rdata_valid_o, rnw); end
        if (rnw) begin
            total++; if (rdata_o !== m_rdata) begin bad++; $display("FAIL %s resp_rdata got=%h exp=%h", nm, rdata_o, m_rdata); end
        end

        // Back in IDLE; a stray ack here must be ignored.
        @(negedge clk);
        mem_ack_i = 1'($urandom); mem_rdata_i = 8'($urandom);
        #1;
        total++; if (wait_o !== 1'b0 || rdata_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL %s idle_ctl got=%b%b%b exp=000", nm, wait_o, rdata_valid_o, mem_req_o); end
        total++; if (rdata_o !== m_rdata) begin bad++; $display("FAIL %s idle_rdata got=%h exp=%h", nm, rdata_o, m_rdata); end
        total++; if (err_timeout_o !== m_err_to || err_overrun_o !== m_err_ov) begin bad++; $display("FAIL %s flags got=%b%b exp=%b%b", nm, err_timeout_o, err_overrun_o, m_err_to, m_err_ov); end
        @(negedge clk);
        mem_ack_i = 0;
        #1;
        total++; if (rdata_o !== m_rdata || mem_req_o !== 1'b0) begin bad++; $display("FAIL %s stray_ack rdata=%h req=%b exp=%h 0", nm, rdata_o, mem_req_o, m_rdata); end
    endtask

    task automatic check_reset_vals(input string nm);
        total++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || wait_o !== 1'b0 || rdata_valid_o !== 1'b0) begin bad++; $display("FAIL %s ctl got=%b%b%b%b exp=0000", nm, mem_req_o, mem_we_o, wait_o, rdata_valid_o); end
        total++; if (err_timeout_o !== 1'b0 || err_overrun_o !== 1'b0) begin bad++; $display("FAIL %s flags got=%b%b exp=00", nm, err_timeout_o, err_overrun_o); end
        total++; if (rdata_o !== 8'hFF) begin bad++; $display("FAIL %s rdata got=%h exp=ff", nm, rdata_o); end
        total++; if (mem_addr_o !== '0 || mem_wdata_o !== 8'h00) begin bad++; $display("FAIL %s addr_wdata got=%h %h exp=0 0", nm, mem_addr_o, mem_wdata_o); end
    endtask

    task automatic test_reset();
        reset_n = 0; req_i = 0; ram_cs_i = 0; rnw_i = 0; addr_i = '0; wdata_i = '0;
        mem_ack_i = 0; mem_rdata_i = '0; err_clr_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1;
        #1;
        check_reset_vals("post_reset");
    endtask

    task automatic test_read_miss();
        do_access(1, 27'h0004000, 8'h00, 3, 8'h5A, -1, 0, "read_miss");
    endtask

    task automatic test_read_hit();
        do_access(1, 27'h0004000, 8'h11, 0, 8'h99, -1, 0, "read_hit");
    endtask

    task automatic test_write_then_read();
        do_access(0, 27'h0004000, 8'hC3, 1, 8'h00, -1, 0, "write_tag");
        do_access(1, 27'h0004000, 8'h00, 0, 8'h77, -1, 0, "read_after_write");
        // Write elsewhere must leave the buffer alone.
        do_access(0, 27'h0004001, 8'h3C, 0, 8'h00, -1, 0, "write_other");
        do_access(1, 27'h0004000, 8'h00, 0, 8'h77, -1, 0, "read_after_other");
        // Differs only in the top address bit: must miss.
        do_access(1, 27'h4004000, 8'h00, 2, 8'hA5, -1, 0, "read_msb_miss");
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        req_i = 1; ram_cs_i = 0; rnw_i = 1; addr_i = 27'h0004000;
        #1;
        total++; if (wait_o !== 1'b0) begin bad++; $display("FAIL unmapped wait got=%b exp=0", wait_o); end
        @(negedge clk);
        req_i = 0;
        #1;
        total++; if (mem_req_o !== 1'b0 || wait_o !== 1'b0 || rdata_valid_o !== 1'b0) begin bad++; $display("FAIL unmapped after got=%b%b%b exp=000", mem_req_o, wait_o, rdata_valid_o); end
    endtask

    task automatic test_timeout();
        do_access(1, 27'h0123456, 8'h00, 1000, 8'h00, -1, 0, "timeout_read");
        repeat (3) @(negedge clk);
        #1;
        total++; if (err_timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout_o); end
        @(negedge clk);
        err_clr_i = 1;
        @(negedge clk);
        err_clr_i = 0; m_err_to = 0; m_err_ov = 0;
        #1;
        total++; if (err_timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b exp=0", err_timeout_o); end
        // Ack in the last allowed cycle wins over the timeout.
        do_access(1, 27'h0123456, 8'h00, TO - 1, 8'h6E, -1, 0, "ack_at_limit");
        do_access(0, 27'h0000777, 8'h42, 1000, 8'h00, -1, 0, "timeout_write");
        do_access(1, 27'h0123456, 8'h00, 0, 8'h00, -1, 0, "hit_after_to");
    endtask

    task automatic test_overrun();
        do_access(1, 27'h0055555, 8'h00, 4, 8'hD2, 1, 0, "overrun");
        do_access(1, 27'h0066666, 8'h00, 1000, 8'h00, -1, 0, "to_before_clr");
        // Overrun and clear together: overrun set wins, timeout cleared.
        do_access(1, 27'h0077777, 8'h00, 2, 8'h1F, 0, 1, "overrun_clr");
    endtask

    task automatic test_reset_mid_issue();
        @(negedge clk);
        req_i = 1; ram_cs_i = 1; rnw_i = 1; addr_i = 27'h0010000;
        @(negedge clk);
        req_i = 0;
        @(negedge clk);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        check_reset_vals("reset_mid_issue");
        @(negedge clk);
        reset_n = 1; mem_ack_i = 1; mem_rdata_i = 8'hEE;
        #1;
        total++; if (mem_req_o !== 1'b0 || rdata_valid_o !== 1'b0) begin bad++; $display("FAIL late_ack got=%b%b exp=00", mem_req_o, rdata_valid_o); end
        @(negedge clk);
        mem_ack_i = 0;
        #1;
        total++; if (rdata_valid_o !== 1'b0 || rdata_o !== 8'hFF) begin bad++; $display("FAIL late_ack_after got=%b %h exp=0 ff", rdata_valid_o, rdata_o); end
        do_access(1, 27'h0004000, 8'h00, 2, 8'h3B, -1, 0, "miss_after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit            rnw;
            logic [AW-1:0] a;
            int            dly;
            int            ovr;
            rnw = 1'($urandom_range(0, 2) != 0);
            a   = pool[$urandom_range(0, 5)];
            dly = $urandom_range(0, TO + 1);
            ovr = -1;
            if ($urandom_range(0, 3) == 0)
                ovr = $urandom_range(0, (dly < TO) ? dly : TO - 1);
            do_access(rnw, a, 8'($urandom), dly, 8'($urandom), ovr,
                      1'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                err_clr_i = 1;
                @(negedge clk);
                err_clr_i = 0; m_err_to = 0; m_err_ov = 0;
            end
        end
    endtask

    initial begin
        pool[0] = 27'h0004000; pool[1] = 27'h4004000; pool[2] = 27'h0000000;
        pool[3] = 27'h7FFFFFF; pool[4] = 27'h0004001; pool[5] = 27'h2AAAAAA;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_then_read();
        test_unmapped();
        test_timeout();
        test_overrun();
        test_reset_mid_issue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mapper_ram_bridge.md
MAPPER_RAM_BRIDGE -- requirements
Module: mapper_ram_bridge

Interface
REQ-001 Parameter AW, default 27, SHALL set the width of the mapper/memory byte address.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles waited for mem_ack_i (1..255).
REQ-003 Clock: clk, input, 1 bit, rising-edge system clock (cpu_bus clock domain).
REQ-004 Reset: reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 req_i, input, 1: one-cycle start strobe of a CPU memory cycle.
REQ-006 ram_cs_i, input, 1: mapper RAM select for the current cycle.
REQ-007 rnw_i, input, 1: 1 = read, 0 = write.
REQ-008 addr_i, input, AW: mapper RAM byte address.
REQ-009 wdata_i, input, 8: CPU write data.
REQ-010 rdata_o, output, 8: read data to CPU; held until next completion.
REQ-011 rdata_valid_o, output, 1: one-cycle read completion pulse.
REQ-012 wait_o, output, 1: CPU wait request.
REQ-013 mem_req_o, mem_we_o, outputs, 1 each: memory request and write enable.
REQ-014 mem_addr_o (AW) and mem_wdata_o (8), outputs: memory address and write data.
REQ-015 mem_ack_i (1) and mem_rdata_i (8), inputs: completion and read data, valid in the ack cycle.
REQ-016 err_timeout_o and err_overrun_o, outputs, 1 each: sticky error flags.
REQ-017 err_clr_i, input, 1: clears both sticky flags.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-019 Accept: in IDLE, req_i=1 with ram_cs_i=1 SHALL latch addr_i, rnw_i and wdata_i.
REQ-020 Unmapped: req_i with ram_cs_i=0 SHALL be ignored; no wait, no memory access.
REQ-021 wait_o SHALL be combinational: 1 when (IDLE and req_i and ram_cs_i) or state != IDLE.
REQ-022 Read-buffer hit: a read whose address equals the valid buffer tag SHALL go IDLE->RESP without a memory access.
REQ-023 Hit data: it SHALL return the buffered byte with rdata_valid_o in the cycle after req_i.
REQ-024 Other accepted requests SHALL go IDLE->ISSUE.
REQ-025 ISSUE SHALL drive mem_req_o=1 with mem_addr_o, mem_we_o=~rnw and mem_wdata_o held constant from the cycle after req_i until ack.
REQ-026 ack sampled at cycle n SHALL deassert mem_req_o at n+1 and move to RESP at n+1.
REQ-027 Read completion SHALL capture mem_rdata_i into rdata_o, the buffer data and the tag, and set the buffer valid.
REQ-028 A write to the tagged address SHALL update the buffer data on ack; other writes leave the buffer unchanged.
REQ-029 RESP SHALL last exactly one cycle: rdata_valid_o=1 for reads (0 for writes), then IDLE; wait_o=1 in RESP.
REQ-030 Minimum uncached latency: req_i at cycle 0, ack at cycle 1 -> RESP and rdata_valid_o at cycle 2; wait_o high cycles 0-2.
REQ-031 Timeout: an 8-bit counter SHALL clear on entry to ISSUE and count each cycle without ack.
REQ-032 On reaching TIMEOUT, the bridge SHALL drop mem_req_o, go to RESP, return 8'hFF for reads, and set err_timeout_o.
REQ-033 A timed-out access SHALL leave the buffer unchanged.
REQ-034 Ack arriving in the same cycle the count reaches TIMEOUT SHALL win: normal completion, no error.
REQ-035 Overrun: req_i with ram_cs_i while state != IDLE SHALL be dropped and set err_overrun_o; the in-flight access is unaffected.
REQ-036 mem_ack_i outside ISSUE SHALL be ignored.
REQ-037 err_clr_i SHALL clear both flags; a set event in the same cycle SHALL win over the clear.
REQ-038 Address width arithmetic: the tag compare SHALL use all AW bits; the counter SHALL not wrap (saturates at TIMEOUT).

Reset
REQ-039 Asserting reset_n=0 SHALL immediately force IDLE and set mem_req_o, mem_we_o, wait_o, rdata_valid_o and both error flags to 0.
REQ-040 Reset SHALL set rdata_o to 8'hFF, mem_addr_o and mem_wdata_o to 0, the buffer valid to 0 and the counter to 0.
REQ-041 Reset during ISSUE SHALL abort the access without a response; a later mem_ack_i SHALL be ignored.

Verification
REQ-042 Read of 0x0004000 with ack 3 cycles after mem_req_o and mem_rdata_i=0x5A -> one mem_req_o burst with mem_we_o=0; rdata_o=0x5A with a one-cycle rdata_valid_o; wait_o drops the cycle after that pulse.
REQ-043 Repeat read of 0x0004000 -> no mem_req_o; rdata_o=0x5A with rdata_valid_o one cycle after req_i.
REQ-044 Write 0xC3 to 0x0004000, then read it -> write issued with mem_we_o=1 and mem_wdata_o=0xC3; the read hits and returns 0xC3 with no memory access.
REQ-045 Read with mem_ack_i never asserted, TIMEOUT=8 -> mem_req_o drops after 8 cycles; rdata_o=0xFF; err_timeout_o=1 until err_clr_i.
REQ-046 Second req_i while in ISSUE -> err_overrun_o=1; the first access completes normally; exactly one mem_req_o burst.
REQ-047 reset_n pulsed low mid-ISSUE, then mem_ack_i -> all outputs at reset values; no rdata_valid_o; a following read of 0x0004000 misses.
